// File: rtl/downsample_engine.sv
// 2x2 box-filter downsampler: reads each 2x2 source block from DRAM, writes one averaged pixel.
// Optional build macro DS_ROUND_EN selects round-half-up instead of truncation for the average.
module downsample_engine #(
    parameter int IMG_W_LOG2 = 8,
    parameter int IMG_H_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        wr_en,
    output logic        busy,
    output logic        done
);

    localparam int CW = IMG_W_LOG2 - 1;
    localparam int RW = IMG_H_LOG2 - 1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        ACC,
        WR,
        DONE
    } state_t;

    state_t          state;
    logic [1:0]      k;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [9:0]      acc_p1;
    logic [9:0]      acc_sum;
    logic            last_col;
    logic            last_row;
    logic [CW-1:0]   col_nxt;
    logic [RW-1:0]   row_nxt;

    // Source address: row bits {r,dy}, column bits {c,dx}, row-major with power-of-two width.
    function automatic logic [15:0] src_addr(input logic [RW-1:0] r, input logic [CW-1:0] c,
                                             input logic [1:0] kk);
        return 16'({r, kk[1], c, kk[0]});
    endfunction

    function automatic logic [7:0] avg_pix(input logic [9:0] sum);
`ifdef DS_ROUND_EN
        return 8'(({1'b0, sum} + 11'd2) >> 2);
`else
        return 8'(sum >> 2);
`endif
    endfunction

    always_comb begin
        acc_sum  = acc_p1 + {2'b00, rd_data};
        last_col = &col;
        last_row = &row;
        col_nxt  = col + 1'b1;
        row_nxt  = last_col ? row + 1'b1 : row;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            k       <= 2'd0;
            col     <= '0;
            row     <= '0;
            acc_p1  <= 10'd0;
            rd_addr <= 16'd0;
            wr_addr <= 16'd0;
            wr_data <= 8'd0;
            wr_en   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RD;
                        k       <= 2'd0;
                        col     <= '0;
                        row     <= '0;
                        rd_addr <= src_addr('0, '0, 2'd0);
                        busy    <= 1'b1;
                    end
                end
                // RD: address k presented this cycle, data of k-1 arrives and is summed
                RD: begin
                    if (k == 2'd0) begin
                        acc_p1 <= 10'd0;
                    end else begin
                        acc_p1 <= acc_sum;
                    end
                    k <= k + 2'd1;
                    if (k == 2'd3) begin
                        state <= ACC;
                    end else begin
                        rd_addr <= src_addr(row, col, k + 2'd1);
                    end
                end
                // ACC: last sample of the block lands, result registered for the write cycle
                ACC: begin
                    acc_p1  <= acc_sum;
                    wr_data <= avg_pix(acc_sum);
                    wr_addr <= 16'({row, col});
                    wr_en   <= 1'b1;
                    state   <= WR;
                end
                WR: begin
                    k <= 2'd0;
                    if (last_col && last_row) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        col     <= col_nxt;
                        row     <= row_nxt;
                        rd_addr <= src_addr(row_nxt, col_nxt, 2'd0);
                        state   <= RD;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_downsample_engine.sv
// Randomized bench for downsample_engine on a reduced 16x8 image against an arithmetic block-average model.
module tb_downsample_engine;

    localparam int WL       = 4;
    localparam int HL       = 3;
    localparam int W        = 1 << WL;
    localparam int H        = 1 << HL;
    localparam int OW       = W / 2;
    localparam int NPIX     = (W / 2) * (H / 2);
    localparam int PASS_CYC = 6 * NPIX;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        busy;
    logic        done;

    logic [7:0]  src [0:W*H-1];
    int          total = 0;
    int          bad = 0;

    downsample_engine #(.IMG_W_LOG2(WL), .IMG_H_LOG2(HL)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // DRAM model: one-cycle read latency
    always @(posedge clk) rd_data <= src[rd_addr[WL+HL-1:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int model_pix(input int p);
        int r, c, s;
        r = p / OW;
        c = p % OW;
        s = 0;
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++)
                s += int'(src[(2*r+dy)*W + 2*c + dx]);
`ifdef DS_ROUND_EN
        return (s + 2) / 4;
`else
        return s / 4;
`endif
    endfunction

    function automatic int model_rd(input int p, input int kk);
        int r, c;
        r = p / OW;
        c = p % OW;
        return (2*r + kk/2) * W + 2*c + kk%2;
    endfunction

    task automatic run_pass(input string name, input bit poke, output int first_wd);
        int wa[$];
        int wd[$];
        int wc[$];
        int ndone, done_j, busy_err, range_err;
        ndone = 0; done_j = -1; busy_err = 0; range_err = 0; first_wd = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 0; j < PASS_CYC + 14; j++) begin
            if (j < PASS_CYC && (j % 6) < 4)
                chk({name, ".rd_addr"}, 32'(rd_addr), 32'(model_rd(j / 6, j % 6)));
            if (j < PASS_CYC && busy !== 1'b1) busy_err++;
            if (rd_addr >= 16'(W*H) || (wr_en && wr_addr >= 16'(NPIX))) range_err++;
            if (wr_en === 1'b1) begin
                wa.push_back(int'(wr_addr));
                wd.push_back(int'(wr_data));
                wc.push_back(j);
            end
            if (done === 1'b1) begin
                ndone++;
                done_j = j;
                chk({name, ".busy_at_done"}, 32'(busy), 32'd0);
            end
            if (poke && (j == 6*5 + 1 || j == PASS_CYC)) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk({name, ".done_cnt"}, ndone, 1);
        chk({name, ".done_cyc"}, done_j, PASS_CYC);
        chk({name, ".busy_err"}, busy_err, 0);
        chk({name, ".range_err"}, range_err, 0);
        chk({name, ".busy_idle"}, 32'(busy), 32'd0);
        chk({name, ".wr_cnt"}, wa.size(), NPIX);
        for (int i = 0; i < wa.size() && i < NPIX; i++) begin
            chk({name, ".wr_addr"}, wa[i], i);
            chk({name, ".wr_data"}, wd[i], model_pix(i));
            chk({name, ".wr_cyc"}, wc[i], 6*i + 5);
        end
        if (wd.size() > 0) first_wd = wd[0];
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, ".rd_addr"}, 32'(rd_addr), 32'd0);
        chk({name, ".wr_addr"}, 32'(wr_addr), 32'd0);
        chk({name, ".wr_data"}, 32'(wr_data), 32'd0);
        chk({name, ".wr_en"},   32'(wr_en),   32'd0);
        chk({name, ".busy"},    32'(busy),    32'd0);
        chk({name, ".done"},    32'(done),    32'd0);
    endtask

    initial begin
        int fw;
        int wr_seen;
        for (int i = 0; i < W*H; i++) src[i] = 8'h00;

        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle.busy", 32'(busy), 32'd0);

        for (int i = 0; i < W*H; i++) src[i] = 8'h80;
        run_pass("const80", 1'b0, fw);
        chk("const80.first", fw, 32'h80);

        for (int i = 0; i < W*H; i++) src[i] = 8'hFF;
        run_pass("allff", 1'b0, fw);
        chk("allff.first", fw, 32'hFF);

        for (int i = 0; i < W*H; i++) src[i] = 8'($urandom);
        src[0] = 8'd10; src[1] = 8'd11; src[W] = 8'd12; src[W+1] = 8'd13;
        run_pass("block", 1'b0, fw);
`ifdef DS_ROUND_EN
        chk("block.first", fw, 12);
`else
        chk("block.first", fw, 11);
`endif

        for (int i = 0; i < W*H; i++) src[i] = 8'($urandom);
        run_pass("poke", 1'b1, fw);

        // Abandon a pass mid-block, then restart from pixel (0,0)
        for (int i = 0; i < W*H; i++) src[i] = 8'($urandom_range(0, 255));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6*10 + 1) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_outputs_zero("midrst");
        wr_seen = 0;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            if (wr_en !== 1'b0) wr_seen++;
        end
        @(negedge clk) rst_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            if (wr_en !== 1'b0 || busy !== 1'b0) wr_seen++;
        end
        chk("midrst.quiet", wr_seen, 0);
        run_pass("restart", 1'b0, fw);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
